// File: rtl/dual_segment_counter.sv
// Purpose : two-digit BCD up/down counter driving a pair of active-low 7-segment digits.
// Latency : count, o_Tick and o_Wrap update on the tick edge; segments follow combinationally.
// Backpressure: none; i_Enable=0 freezes the prescaler and count in place.
//
// Ports:
//   i_Clk        system clock
//   i_Rst        synchronous reset, active-high
//   i_Enable     1 = counting, 0 = paused (prescaler and count hold)
//   i_Up         direction, sampled only on the tick edge (1 = up, 0 = down)
//   o_Segment1   tens digit, active-low, [6:0] = G,F,E,D,C,B,A
//   o_Segment2   units digit, same encoding
//   o_Wrap       one-cycle pulse on the edge where the count wraps
//   o_Tick       one-cycle pulse on every count step
module dual_segment_counter #(
    parameter int TICK_CYCLES        = 12_500_000,
    parameter int MAX_COUNT          = 99,
    parameter int BLANK_LEADING_ZERO = 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Enable,
    input  logic       i_Up,
    output logic [6:0] o_Segment1,
    output logic [6:0] o_Segment2,
    output logic       o_Wrap,
    output logic       o_Tick
);

    localparam int              PW        = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0]   PRE_LAST  = PW'(TICK_CYCLES - 1);
    localparam logic [3:0]      MAX_TENS  = 4'(MAX_COUNT / 10);
    localparam logic [3:0]      MAX_UNITS = 4'(MAX_COUNT % 10);
    localparam logic [6:0]      SEG_DARK  = 7'b1111111;

    logic [PW-1:0] prescaler;
    logic [3:0]    tens;
    logic [3:0]    units;
    logic [3:0]    tens_nxt;
    logic [3:0]    units_nxt;
    logic          wrap_nxt;

    // Active-low G..A pattern for one BCD digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DARK;
        endcase
        return s;
    endfunction

    // Value the count would take if a tick happened now, in the current direction.
    always_comb begin
        tens_nxt  = tens;
        units_nxt = units;
        wrap_nxt  = 1'b0;
        if (i_Up) begin
            if (tens == MAX_TENS && units == MAX_UNITS) begin
                tens_nxt  = 4'd0;
                units_nxt = 4'd0;
                wrap_nxt  = 1'b1;
            end else if (units == 4'd9) begin
                units_nxt = 4'd0;
                tens_nxt  = tens + 4'd1;
            end else begin
                units_nxt = units + 4'd1;
            end
        end else begin
            if (tens == 4'd0 && units == 4'd0) begin
                tens_nxt  = MAX_TENS;
                units_nxt = MAX_UNITS;
                wrap_nxt  = 1'b1;
            end else if (units == 4'd0) begin
                units_nxt = 4'd9;
                tens_nxt  = tens - 4'd1;
            end else begin
                units_nxt = units - 4'd1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            prescaler <= '0;
            tens      <= 4'd0;
            units     <= 4'd0;
            o_Tick    <= 1'b0;
            o_Wrap    <= 1'b0;
        end else begin
            o_Tick <= 1'b0;
            o_Wrap <= 1'b0;
            // Pausing freezes the prescaler phase; resuming continues from where it stopped.
            if (i_Enable) begin
                if (prescaler == PRE_LAST) begin
                    prescaler <= '0;
                    tens      <= tens_nxt;
                    units     <= units_nxt;
                    o_Tick    <= 1'b1;
                    o_Wrap    <= wrap_nxt;
                end else begin
                    prescaler <= prescaler + PW'(1);
                end
            end
        end
    end

    assign o_Segment1 = (BLANK_LEADING_ZERO != 0 && tens == 4'd0) ? SEG_DARK : seg7(tens);
    assign o_Segment2 = seg7(units);

endmodule
